// File: rtl/top_uart_pkg.sv
// Shared constants and state encodings for the vitals-monitor telemetry UART.
package top_uart_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_BANG  = 8'h21;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam int REPORT_BYTES       = 19;
    localparam int REPORT_BYTES_ALARM = 20;
    localparam int SPO2_ALARM_LIMIT   = 90;
    localparam int BCD_STEPS          = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_CONVERT,
        TX_LOAD,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; byte_ready rises in the last stop-bit cycle so the
// next byte follows with no idle gap.
module uart_tx_byte
    import top_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       busy,
    output logic       tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state, state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_end;
    logic             take;

    assign bit_end    = (bit_cnt == BIT_LAST);
    assign byte_ready = (state == TX_IDLE) || ((state == TX_STOP) && bit_end);
    assign take       = byte_valid && byte_ready;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= TX_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE:  if (take) state_nxt = TX_START;
            TX_START: if (bit_end) state_nxt = TX_DATA;
            TX_DATA:  if (bit_end && (bit_idx == 3'd7)) state_nxt = TX_STOP;
            TX_STOP:  if (bit_end) state_nxt = take ? TX_START : TX_IDLE;
            default:  state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != TX_IDLE);
        tx   = 1'b1;
        case (state)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = shift[0];
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bit_cnt <= '0;
            bit_idx <= '0;
        end else begin
            if (take || bit_end || (state == TX_IDLE)) bit_cnt <= '0;
            else                                       bit_cnt <= bit_cnt + 1'b1;
            if (state == TX_START)                bit_idx <= '0;
            else if ((state == TX_DATA) && bit_end) bit_idx <= bit_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (take)                               shift <= byte_data;
        else if ((state == TX_DATA) && bit_end) shift <= {1'b0, shift[7:1]};
    end

endmodule

// File: rtl/top_uart.sv
// Telemetry UART: periodic "HR:nnnnn SPO2:nnn\r\n" report on tx, LED commands on rx.
// Define TOP_UART_SPO2_ALARM_EN to append '!' to reports whose SpO2 is below 90.
module top_uart
    import top_uart_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD          = 9600,
    parameter int REPORT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_heart_rate,
    input  logic [7:0]  data_spo2,
    input  logic        rx,
    output logic        tx,
    output logic        led_1,
    output logic        led_2
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int TMR_W        = $clog2(REPORT_CYCLES + 1);

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [19:0] adj_hr(input logic [19:0] b);
        return {add3(b[19:16]), add3(b[15:12]), add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
    endfunction

    function automatic logic [11:0] adj_sp(input logic [11:0] b);
        return {add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
    endfunction

    function automatic logic [7:0] digit(input logic [3:0] d);
        return ASCII_ZERO + {4'd0, d};
    endfunction

    logic [TMR_W-1:0] rep_tmr;
    logic             rep_wrap, pending, rep_start;
    tx_state_t        rep_state, rep_nxt;
    logic [4:0]       step_cnt, byte_idx, byte_last;
    logic             conv_en, conv_done, byte_valid, byte_ready, tx_busy, last_take;
    logic [15:0]      hr_sh, sp_sh;
    logic [19:0]      hr_bcd;
    logic [11:0]      sp_bcd;
    logic [7:0]       byte_data;
    logic             alarm;

    assign rep_wrap  = (rep_tmr == TMR_W'(REPORT_CYCLES - 1));
    assign rep_start = pending && (rep_state == TX_IDLE) && !tx_busy;
    assign conv_done = (step_cnt == 5'(BCD_STEPS - 1));
    assign byte_last = alarm ? 5'(REPORT_BYTES_ALARM - 1) : 5'(REPORT_BYTES - 1);
    assign last_take = byte_valid && byte_ready && (byte_idx == byte_last);

    // Wraps collapse into one pending report while the transmitter is busy.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rep_tmr <= '0;
            pending <= 1'b0;
        end else begin
            rep_tmr <= rep_wrap ? '0 : rep_tmr + 1'b1;
            if (rep_wrap)       pending <= 1'b1;
            else if (rep_start) pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) rep_state <= TX_IDLE;
        else       rep_state <= rep_nxt;
    end

    always_comb begin
        rep_nxt = rep_state;
        case (rep_state)
            TX_IDLE:    if (rep_start) rep_nxt = TX_CONVERT;
            TX_CONVERT: if (conv_done) rep_nxt = TX_LOAD;
            TX_LOAD:    if (last_take) rep_nxt = TX_IDLE;
            default:    rep_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        conv_en    = (rep_state == TX_CONVERT);
        byte_valid = (rep_state == TX_LOAD);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            step_cnt <= '0;
            byte_idx <= '0;
        end else begin
            if (rep_start)    step_cnt <= '0;
            else if (conv_en) step_cnt <= step_cnt + 1'b1;
            if (rep_start)                     byte_idx <= '0;
            else if (byte_valid && byte_ready) byte_idx <= byte_idx + 1'b1;
        end
    end

    // Snapshot, then one double-dabble step per cycle for 16 cycles.
    always_ff @(posedge clk) begin
        if (rep_start) begin
            hr_sh  <= data_heart_rate;
            sp_sh  <= {8'd0, data_spo2};
            hr_bcd <= '0;
            sp_bcd <= '0;
        end else if (conv_en) begin
            hr_bcd <= (adj_hr(hr_bcd) << 1) | 20'(hr_sh[15]);
            sp_bcd <= (adj_sp(sp_bcd) << 1) | 12'(sp_sh[15]);
            hr_sh  <= hr_sh << 1;
            sp_sh  <= sp_sh << 1;
        end
    end

`ifdef TOP_UART_SPO2_ALARM_EN
    always_ff @(posedge clk) begin
        if (rep_start) alarm <= (data_spo2 < 8'(SPO2_ALARM_LIMIT));
    end
`else
    assign alarm = 1'b0;
`endif

    always_comb begin
        byte_data = ASCII_LF;
        case (byte_idx)
            5'd0:    byte_data = 8'h48;
            5'd1:    byte_data = 8'h52;
            5'd2:    byte_data = ASCII_COLON;
            5'd3:    byte_data = digit(hr_bcd[19:16]);
            5'd4:    byte_data = digit(hr_bcd[15:12]);
            5'd5:    byte_data = digit(hr_bcd[11:8]);
            5'd6:    byte_data = digit(hr_bcd[7:4]);
            5'd7:    byte_data = digit(hr_bcd[3:0]);
            5'd8:    byte_data = ASCII_SPACE;
            5'd9:    byte_data = 8'h53;
            5'd10:   byte_data = 8'h50;
            5'd11:   byte_data = 8'h4F;
            5'd12:   byte_data = 8'h32;
            5'd13:   byte_data = ASCII_COLON;
            5'd14:   byte_data = digit(sp_bcd[11:8]);
            5'd15:   byte_data = digit(sp_bcd[7:4]);
            5'd16:   byte_data = digit(sp_bcd[3:0]);
            5'd17:   byte_data = alarm ? ASCII_BANG : ASCII_CR;
            5'd18:   byte_data = alarm ? ASCII_CR : ASCII_LF;
            default: byte_data = ASCII_LF;
        endcase
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (tx_busy),
        .tx         (tx)
    );

    rx_state_t        rx_state, rx_nxt;
    logic             rx_s1, rx_s2, rx_vld, rx_shift_en, rx_done;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_sh;
    logic             rx_half, rx_bit_end;

    assign rx_half    = (rx_cnt == CNT_W'(HALF_BIT));
    assign rx_bit_end = (rx_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= RX_IDLE;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_state <= rx_nxt;
        end
    end

    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            RX_IDLE:      if (!rx_s2) rx_nxt = RX_START;
            RX_START:     if (rx_half) rx_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_bit_end && (rx_idx == 3'd7)) rx_nxt = RX_STOP;
            RX_STOP:      if (rx_bit_end) rx_nxt = rx_s2 ? RX_IDLE : RX_WAIT_IDLE;
            RX_WAIT_IDLE: if (rx_s2) rx_nxt = RX_IDLE;
            default:      rx_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_shift_en = (rx_state == RX_DATA) && rx_bit_end;
        rx_done     = (rx_state == RX_STOP) && rx_bit_end && rx_s2;
    end

    // Counter restarts on every state change, so data samples land one bit after mid-start.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rx_cnt <= '0;
            rx_idx <= '0;
            rx_vld <= 1'b0;
            led_1  <= 1'b0;
            led_2  <= 1'b0;
        end else begin
            if ((rx_state == RX_IDLE) || (rx_state == RX_WAIT_IDLE) ||
                (rx_state != rx_nxt) || rx_bit_end)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_START) rx_idx <= '0;
            else if (rx_shift_en)     rx_idx <= rx_idx + 1'b1;
            rx_vld <= rx_done;
            if (rx_vld) begin
                led_1 <= rx_sh[0];
                led_2 <= rx_sh[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_shift_en) rx_sh <= {rx_s2, rx_sh[7:1]};
    end

endmodule

// File: tb/tb_top_uart.sv
// Bench for top_uart: scoreboarded report decoding, RX LED commands and a back-to-back report instance.
module tb_top_uart;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int RC1      = 3000;
    localparam int RC2      = 500;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] hr1 = 16'd0, hr2 = 16'd300;
    logic [7:0]  sp1 = 8'd0,  sp2 = 8'd95;
    logic        rx1 = 1'b1,  rx2 = 1'b1;
    logic        tx1, tx2, led1_1, led1_2, led2_1, led2_2;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   rel_cyc  = 0;
    int   first_lo = -1;
    int   bytes1   = 0;
    int   bytes2   = 0;
    int   total1   = 0;
    bq_t  sb1;
    bq_t  ref2;

    top_uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .REPORT_CYCLES(RC1)) dut1 (
        .clk(clk), .rst_n(rst), .data_heart_rate(hr1), .data_spo2(sp1),
        .rx(rx1), .tx(tx1), .led_1(led1_1), .led_2(led1_2)
    );

    top_uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .REPORT_CYCLES(RC2)) dut2 (
        .clk(clk), .rst_n(rst), .data_heart_rate(hr2), .data_spo2(sp2),
        .rx(rx2), .tx(tx2), .led_1(led2_1), .led_2(led2_2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bq_t make_report(input int hr, input int sp);
        bq_t   r;
        string s;
        s = $sformatf("HR:%05d SPO2:%03d", hr, sp);
        for (int i = 0; i < s.len(); i++) r.push_back(s[i]);
`ifdef TOP_UART_SPO2_ALARM_EN
        if (sp < 90) r.push_back(8'h21);
`endif
        r.push_back(8'h0D);
        r.push_back(8'h0A);
        return r;
    endfunction

    task automatic push_report(input int hr, input int sp);
        bq_t r;
        r = make_report(hr, sp);
        foreach (r[i]) sb1.push_back(r[i]);
        total1 += r.size();
    endtask

    task automatic get_byte(input int which, output logic [7:0] b);
        repeat (CPB / 2) @(negedge clk);
        check(which != 0 ? "start_bit2" : "start_bit1", which != 0 ? tx2 : tx1, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = (which != 0) ? tx2 : tx1;
        end
        repeat (CPB) @(negedge clk);
        check(which != 0 ? "stop_bit2" : "stop_bit1", which != 0 ? tx2 : tx1, 1);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        rx1 = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx1 = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx1 = stop;
        repeat (CPB) @(negedge clk);
        rx1 = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin : mon1
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && tx1 === 1'b0) begin
                if (first_lo < 0) first_lo = cyc;
                get_byte(0, b);
                bytes1++;
                if (sb1.size() == 0) check("sb1_unexpected_byte", sb1.size(), 1);
                else begin
                    e = sb1.pop_front();
                    check("report_byte", b, e);
                end
            end
        end
    end

    initial begin : mon2
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && tx2 === 1'b0) begin
                get_byte(1, b);
                check("b2b_report_byte", b, ref2[bytes2 % ref2.size()]);
                bytes2++;
            end
        end
    end

    initial begin
        ref2 = make_report(300, 95);
        hr1  = 16'd75;
        sp1  = 8'd98;
        push_report(75, 98);

        repeat (5) begin
            @(negedge clk);
            check("reset_tx", tx1, 1);
            check("reset_led1", led1_1, 0);
            check("reset_led2", led1_2, 0);
        end
        rst     = 1'b0;
        rel_cyc = cyc;

        wait_cyc(rel_cyc + 3800);
        check("first_report_not_early", (first_lo - rel_cyc) >= RC1, 1);
        check("first_report_not_late", (first_lo - rel_cyc) <= RC1 + 40, 1);
        hr1 = 16'd125;
        sp1 = 8'd80;
        push_report(125, 80);

        wait_cyc(rel_cyc + 6100);
        send_rx(8'h55, 1'b1);
        check("rx55_led1", led1_1, 1);
        check("rx55_led2", led1_2, 0);
        send_rx(8'h02, 1'b1);
        check("rx02_led1", led1_1, 0);
        check("rx02_led2", led1_2, 1);
        send_rx(8'h03, 1'b0);
        check("framing_err_led1", led1_1, 0);
        check("framing_err_led2", led1_2, 1);
        rx1 = 1'b0;
        repeat (3) @(negedge clk);
        rx1 = 1'b1;
        repeat (15 * CPB) @(negedge clk);
        check("glitch_led1", led1_1, 0);
        check("glitch_led2", led1_2, 1);
        send_rx(8'h01, 1'b1);
        check("rx01_led1", led1_1, 1);
        check("rx01_led2", led1_2, 0);

        wait_cyc(rel_cyc + 8500);
        hr1 = 16'd65535;
        sp1 = 8'd255;
        push_report(65535, 255);

        wait_cyc(rel_cyc + 11500);
        check("sb1_drained", sb1.size(), 0);
        check("report_byte_count", bytes1, total1);
        check("b2b_byte_count", bytes2 >= 95, 1);
        check("b2b_led1_idle", led2_1, 0);
        check("b2b_led2_idle", led2_2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
